spi_cmd_ram: RTL
================

Name: spi_cmd_ram

Overview:
Command-decoding memory stage directly downstream of the SPI slave FSM. It consumes the FSM's 10-bit rx_data/rx_valid words, decodes the 2-bit command, and maintains write- and read-address registers. It writes or reads an internal byte array and returns read bytes on tx_data/tx_valid for the FSM to serialise onto MISO.

Parameters:
MEM_DEPTH, 256, number of byte locations.
ADDR_SIZE, 8, address width; MEM_DEPTH <= 2**ADDR_SIZE.
AUTO_INC, 0, if 1, post-increment the write address after each write-data and the read address after each read-data.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
rx_data  input  10  [9:8] command, [7:0] payload
rx_valid  input  1  level from FSM; command taken on its rising edge only
tx_data  output  8  read byte
tx_valid  output  1  read byte valid, held until the next accepted command
seq_err  output  1  one-cycle pulse on an out-of-order command

Behaviour:
- Single clock domain; rst_n is asynchronous and active-low. All registers clear on rst_n=0 regardless of any in-progress operation. Memory array contents are not reset.
- Reset values: tx_data=0, tx_valid=0, seq_err=0, wr_addr=0, rd_addr=0, rx_valid_d=0, state=IDLE.
- Accept: accept = rx_valid & ~rx_valid_d, where rx_valid_d is rx_valid registered. There is one command per rising edge; a held-high rx_valid never re-triggers.
- Command codes:
  - 00 WR_ADDR: wr_addr <= payload.
  - 01 WR_DATA: mem[wr_addr] <= payload.
  - 10 RD_ADDR: rd_addr <= payload.
  - 11 RD_DATA: payload is ignored (dummy); read mem[rd_addr].
- FSM states and transitions:
  - IDLE:
    - 00 -> WA_SET.
    - 10 -> RA_SET.
    - 01 or 11 -> seq_err pulse, command dropped, stay IDLE.
  - WA_SET:
    - 01 -> write, stay WA_SET.
    - 00 -> reload address, stay WA_SET.
    - 10 -> BOTH_SET.
    - 11 -> seq_err, stay WA_SET.
  - RA_SET:
    - 11 -> read, stay RA_SET.
    - 10 -> reload address, stay RA_SET.
    - 00 -> BOTH_SET.
    - 01 -> seq_err, stay RA_SET.
  - BOTH_SET: all four commands legal; remain BOTH_SET.
- Read latency:
  - RD_DATA accepted at edge N -> tx_data=mem[rd_addr] and tx_valid=1 after edge N+1.
  - Both hold until the edge following the next accepted command, at which tx_valid drops to 0 (unless that command is another legal RD_DATA, in which case the new byte replaces the old and tx_valid stays 1).
- Write: data is visible to a read accepted at least one cycle later. Read-after-write to the same address in consecutive accepts returns the new data.
- Addresses >= MEM_DEPTH wrap modulo MEM_DEPTH (index with the low bits; MEM_DEPTH is a power of two).
- AUTO_INC: the increment wraps from MEM_DEPTH-1 to 0. The increment is applied in the same edge as the access.
- seq_err: a single-cycle pulse one edge after the offending accept. Dropped commands change no address register, memory location or tx outputs.
- rx_valid rising in the same cycle rst_n deasserts: rx_valid_d is already 0, so the command is accepted on the first clock after release.

Decomposition:
- Shared package spi_pkg holds:
  - Command localparams CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
  - State encodings IDLE, WA_SET, RA_SET, BOTH_SET.
  - Field slice positions CMD_MSB=9, CMD_LSB=8.
- One sub-module, spi_ram_array: synchronous-write, registered-read byte array (clk, we, waddr, wdata, re, raddr, rdata). It has no reset on storage.

Test Plan:
1. Reset with rx_valid=0 -> tx_valid=0, tx_data=0, seq_err=0, state IDLE.
2. Write then read:
   - Stimulus: 0x0_3A (WR_ADDR 3A), 0x1_C5 (WR_DATA C5), 0x2_3A (RD_ADDR 3A), 0x3_00 (RD_DATA).
   - Required: tx_valid rises one clock after the RD_DATA accept with tx_data=0xC5, and stays 1 for 20 idle clocks.
3. Out-of-order commands:
   - After reset, send 0x1_55 -> seq_err pulses 1 cycle and state stays IDLE.
   - Then 0x3_00 -> another seq_err, and tx_valid stays 0.
4. Held rx_valid: drive rx_valid high for 12 clocks with 0x1_77 in WA_SET (address 0x10) -> exactly one write; reading 0x10 returns 0x77.
5. AUTO_INC=1, wrap at the top of memory:
   - Stimulus: WR_ADDR FF, WR_DATA 11, WR_DATA 22, then RD_ADDR FF, RD_DATA, RD_DATA.
   - Required: tx_data sequence 0x11 then 0x22 (address wrapped to 0x00).
6. Mid-operation reset: pull rst_n low for 1 cycle while tx_valid=1 -> tx_valid=0 immediately (asynchronous). A following RD_DATA raises seq_err, because the state is back to IDLE.

Source files
------------

// File: rtl/spi_cmd_ram_pkg.sv
// Shared definitions for the SPI command-decoding memory stage.
package spi_pkg;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   localparam int CMD_MSB = 9;
   localparam int CMD_LSB = 8;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WA_SET   = 2'd1,
      RA_SET   = 2'd2,
      BOTH_SET = 2'd3
   } state_t;

   // A data command is only meaningful once its address register has been loaded.
   function automatic logic isLegal(input state_t s, input logic [1:0] cmd);
      logic legal;
      case (s)
         IDLE:    legal = (cmd == CMD_WR_ADDR) || (cmd == CMD_RD_ADDR);
         WA_SET:  legal = (cmd != CMD_RD_DATA);
         RA_SET:  legal = (cmd != CMD_WR_DATA);
         default: legal = 1'b1;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/spi_cmd_ram_if.sv
// Word-level link between the SPI slave FSM (master) and the command RAM (slave).
interface spi_cmd_ram_if;
   logic [9:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       seq_err;

   modport master (output rx_data, rx_valid, input tx_data, tx_valid, seq_err);
   modport slave  (input rx_data, rx_valid, output tx_data, tx_valid, seq_err);
endinterface

// File: rtl/spi_cmd_ram_array.sv
// Byte storage with synchronous write and registered read; contents are never reset.
module spi_ram_array #(
   parameter int MEM_DEPTH = 256,
   parameter int IDX_W     = 8
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] waddr,
   input  logic [7:0]       wdata,
   input  logic             re,
   input  logic [IDX_W-1:0] raddr,
   output logic [7:0]       rdata
);

   logic [7:0] r_mem [MEM_DEPTH];
   logic [7:0] r_rdata;

   // Write port and registered read port share the clock; read returns old data on a same-address collision.
   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
      if (re) begin
         r_rdata <= r_mem[raddr];
      end
   end

   assign rdata = r_rdata;

endmodule

// File: rtl/spi_cmd_ram.sv
// Command decoder and address registers sitting behind the SPI slave FSM.
import spi_pkg::*;

module spi_cmd_ram #(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8,
   parameter int AUTO_INC  = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   spi_cmd_ram_if.slave  bus
);

   localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   state_t               r_state;
   logic                 r_rxValidD;
   logic [ADDR_SIZE-1:0] r_wrAddr;
   logic [ADDR_SIZE-1:0] r_rdAddr;
   logic                 r_rdPending;
   logic                 r_legalD;
   logic [7:0]           r_txData;
   logic                 r_txValid;
   logic                 r_seqErr;

   logic                 w_accept;
   logic [1:0]           w_cmd;
   logic [7:0]           w_payload;
   logic [ADDR_SIZE-1:0] w_payAddr;
   logic                 w_legal;
   logic                 w_take;
   logic                 w_we;
   logic                 w_re;
   logic [IDX_W-1:0]     w_wrIdx;
   logic [IDX_W-1:0]     w_rdIdx;
   logic [IDX_W-1:0]     w_wrIdxNext;
   logic [IDX_W-1:0]     w_rdIdxNext;
   logic [7:0]           w_rdata;

   assign w_accept    = bus.rx_valid & ~r_rxValidD;
   assign w_cmd       = bus.rx_data[CMD_MSB:CMD_LSB];
   assign w_payload   = bus.rx_data[7:0];
   assign w_payAddr   = ADDR_SIZE'(w_payload);
   assign w_legal     = isLegal(r_state, w_cmd);
   assign w_take      = w_accept & w_legal;
   assign w_we        = w_take & (w_cmd == CMD_WR_DATA);
   assign w_re        = w_take & (w_cmd == CMD_RD_DATA);
   assign w_wrIdx     = r_wrAddr[IDX_W-1:0];
   assign w_rdIdx     = r_rdAddr[IDX_W-1:0];
   assign w_wrIdxNext = w_wrIdx + 1'b1;
   assign w_rdIdxNext = w_rdIdx + 1'b1;

   spi_ram_array #(
      .MEM_DEPTH (MEM_DEPTH),
      .IDX_W     (IDX_W)
   ) u_array (
      .clk   (clk),
      .we    (w_we),
      .waddr (w_wrIdx),
      .wdata (w_payload),
      .re    (w_re),
      .raddr (w_rdIdx),
      .rdata (w_rdata)
   );

   // Edge detect, sequencing FSM, address registers and the tx/seq_err outputs, all registered together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_rxValidD  <= 1'b0;
         r_wrAddr    <= '0;
         r_rdAddr    <= '0;
         r_rdPending <= 1'b0;
         r_legalD    <= 1'b0;
         r_txData    <= 8'h00;
         r_txValid   <= 1'b0;
         r_seqErr    <= 1'b0;
      end else begin
         r_rxValidD  <= bus.rx_valid;
         r_seqErr    <= w_accept & ~w_legal;
         r_rdPending <= w_re;
         r_legalD    <= w_take;

         if (r_rdPending) begin
            r_txData  <= w_rdata;
            r_txValid <= 1'b1;
         end else if (r_legalD) begin
            r_txValid <= 1'b0;
         end

         if (w_take) begin
            case (w_cmd)
               CMD_WR_ADDR: begin
                  r_wrAddr <= w_payAddr;
                  if (r_state == IDLE)        r_state <= WA_SET;
                  else if (r_state == RA_SET) r_state <= BOTH_SET;
               end
               CMD_WR_DATA: begin
                  if (AUTO_INC != 0) r_wrAddr <= ADDR_SIZE'(w_wrIdxNext);
               end
               CMD_RD_ADDR: begin
                  r_rdAddr <= w_payAddr;
                  if (r_state == IDLE)        r_state <= RA_SET;
                  else if (r_state == WA_SET) r_state <= BOTH_SET;
               end
               default: begin
                  if (AUTO_INC != 0) r_rdAddr <= ADDR_SIZE'(w_rdIdxNext);
               end
            endcase
         end
      end
   end

   assign bus.tx_data  = r_txData;
   assign bus.tx_valid = r_txValid;
   assign bus.seq_err  = r_seqErr;

endmodule
